ysyx_front_core: RTL and testbench

Multi-cycle (non-overlapped) RV32I front end that fetches, decodes and executes one instruction at a time. It combines the fetch (IFU), decode (IDU) and execute (EXU) stages of the ysyx core. It sits between an instruction memory port and an external register file on one side, and the load/store stage (LSU, then WBU) on the other. It owns the PC and hands one execute result per instruction to the LSU over a valid/ready handshake.

---
 rtl/ysyx_front_core.sv | 220 ++++++++++++++++++++++
 tb/tb_ysyx_front_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_front_core.sv
// ysyx_front_core: non-overlapped RV32I fetch/decode/execute front end.
// One instruction in flight; the execute result is handed to the LSU over valid/ready.
module ysyx_front_core #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             exu_valid,
    input  logic             lsu_ready,
    output logic [WIDTH-1:0] exu_pc,
    output logic [WIDTH-1:0] exu_inst,
    output logic [WIDTH-1:0] exu_result,
    output logic [WIDTH-1:0] exu_store_data,
    output logic [4:0]       exu_rd,
    output logic             exu_rd_wen,
    output logic             exu_mem_ren,
    output logic             exu_mem_wen,
    output logic [2:0]       exu_funct3,
    output logic             exu_ebreak,
    output logic             exu_illegal,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] PC
);
    typedef enum logic [1:0] {S_IDLE, S_IF, S_ID, S_EX} state_t;

    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_SYS   = 7'h73;

    state_t           state, state_nx;
    logic             boot;
    logic [WIDTH-1:0] pc, inst_q, npc_q;

    logic [6:0]       opcode, f7;
    logic [2:0]       f3;
    logic [WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, pc4;
    logic [WIDTH-1:0] op_b, alu_out;
    logic [4:0]       shamt;
    logic             taken, legal, wb, ren, wen, ebreak;
    logic [WIDTH-1:0] d_result, d_npc;

    assign imem_addr = pc;
    assign PC        = pc;
    assign inst      = inst_q;
    assign rs1_addr  = inst_q[19:15];
    assign rs2_addr  = inst_q[24:20];

    assign opcode = inst_q[6:0];
    assign f3     = inst_q[14:12];
    assign f7     = inst_q[31:25];
    assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s  = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b  = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u  = {inst_q[31:12], 12'b0};
    assign imm_j  = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    assign pc4    = pc + WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start || boot) state_nx = S_IF;
            S_IF:   state_nx = S_ID;
            S_ID:   state_nx = S_EX;
            S_EX:   if (lsu_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        op_b    = (opcode == OP_REG) ? rs2_data : imm_i;
        shamt   = op_b[4:0];
        alu_out = '0;
        case (f3)
            3'd0: alu_out = (opcode == OP_REG && inst_q[30]) ? rs1_data - op_b : rs1_data + op_b;
            3'd1: alu_out = rs1_data << shamt;
            3'd2: alu_out = WIDTH'($signed(rs1_data) < $signed(op_b));
            3'd3: alu_out = WIDTH'(rs1_data < op_b);
            3'd4: alu_out = rs1_data ^ op_b;
            3'd5: alu_out = inst_q[30] ? WIDTH'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
            3'd6: alu_out = rs1_data | op_b;
            default: alu_out = rs1_data & op_b;
        endcase
        case (f3)
            3'd0: taken = rs1_data == rs2_data;
            3'd1: taken = rs1_data != rs2_data;
            3'd4: taken = $signed(rs1_data) < $signed(rs2_data);
            3'd5: taken = $signed(rs1_data) >= $signed(rs2_data);
            3'd6: taken = rs1_data < rs2_data;
            3'd7: taken = rs1_data >= rs2_data;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        legal    = 1'b1;
        wb       = 1'b0;
        ren      = 1'b0;
        wen      = 1'b0;
        ebreak   = 1'b0;
        d_result = '0;
        d_npc    = pc4;
        case (opcode)
            OP_LUI:   begin wb = 1'b1; d_result = imm_u; end
            OP_AUIPC: begin wb = 1'b1; d_result = pc + imm_u; end
            OP_JAL:   begin wb = 1'b1; d_result = pc4; d_npc = pc + imm_j; end
            OP_JALR: begin
                legal    = (f3 == 3'd0);
                wb       = 1'b1;
                d_result = pc4;
                d_npc    = (rs1_data + imm_i) & ~WIDTH'(1);
            end
            OP_BR: begin
                legal = (f3[2:1] != 2'b01);
                if (taken) d_npc = pc + imm_b;
            end
            OP_LOAD: begin
                legal    = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                wb       = 1'b1;
                ren      = 1'b1;
                d_result = rs1_data + imm_i;
            end
            OP_STORE: begin
                legal    = (f3 < 3'd3);
                wen      = 1'b1;
                d_result = rs1_data + imm_s;
            end
            OP_IMM: begin
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                wb       = 1'b1;
                d_result = alu_out;
            end
            OP_REG: begin
                legal    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                wb       = 1'b1;
                d_result = alu_out;
            end
            OP_SYS: begin
                legal  = (inst_q == 32'h0010_0073);
                ebreak = legal;
            end
            default: legal = 1'b0;
        endcase
        // An undecodable word must not leak any side effect or redirect.
        if (!legal) begin
            wb       = 1'b0;
            ren      = 1'b0;
            wen      = 1'b0;
            ebreak   = 1'b0;
            d_result = '0;
            d_npc    = pc4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_PC;
            boot           <= 1'b1;
            inst_q         <= '0;
            npc_q          <= '0;
            exu_valid      <= 1'b0;
            exu_pc         <= '0;
            exu_inst       <= '0;
            exu_result     <= '0;
            exu_store_data <= '0;
            exu_rd         <= '0;
            exu_rd_wen     <= 1'b0;
            exu_mem_ren    <= 1'b0;
            exu_mem_wen    <= 1'b0;
            exu_funct3     <= '0;
            exu_ebreak     <= 1'b0;
            exu_illegal    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start || boot) boot <= 1'b0;
                S_IF:   inst_q <= imem_rdata;
                S_ID: begin
                    exu_valid      <= 1'b1;
                    exu_pc         <= pc;
                    exu_inst       <= inst_q;
                    exu_result     <= d_result;
                    exu_store_data <= wen ? rs2_data : '0;
                    exu_rd         <= wb ? inst_q[11:7] : 5'd0;
                    exu_rd_wen     <= wb && (inst_q[11:7] != 5'd0);
                    exu_mem_ren    <= ren;
                    exu_mem_wen    <= wen;
                    exu_funct3     <= f3;
                    exu_ebreak     <= ebreak;
                    exu_illegal    <= !legal;
                    npc_q          <= d_npc;
                end
                S_EX: if (lsu_ready) begin
                    exu_valid <= 1'b0;
                    pc        <= npc_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_front_core.sv
// Self-checking bench for ysyx_front_core: directed table, corner sequences,
// and random instructions against an ISA-level reference model.
module tb_ysyx_front_core;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start, lsu_ready;
    logic [31:0] imem_addr, imem_rdata, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, exu_rd;
    logic        exu_valid, exu_rd_wen, exu_mem_ren, exu_mem_wen, exu_ebreak, exu_illegal;
    logic [31:0] exu_pc, exu_inst, exu_result, exu_store_data, inst, PC;
    logic [2:0]  exu_funct3;

    logic [31:0] regs [32];
    logic [31:0] imem_word;
    logic [31:0] mpc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_word;
    assign rs1_data   = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data   = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

    ysyx_front_core #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .exu_pc(exu_pc), .exu_inst(exu_inst), .exu_result(exu_result),
        .exu_store_data(exu_store_data), .exu_rd(exu_rd), .exu_rd_wen(exu_rd_wen),
        .exu_mem_ren(exu_mem_ren), .exu_mem_wen(exu_mem_wen), .exu_funct3(exu_funct3),
        .exu_ebreak(exu_ebreak), .exu_illegal(exu_illegal), .inst(inst), .PC(PC)
    );

    typedef struct {
        logic [31:0] result, store, npc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        wen, mren, mwen, ebreak, ill;
    } exp_t;

    typedef struct {
        bit          rst_before;
        logic [31:0] w, x1, x2, result, store, npc;
        logic [4:0]  rd;
        logic        wen, mwen, ebreak, ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slt_s(input logic [31:0] a, input logic [31:0] b);
        return {31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
    endfunction

    // ISA-level reference: field extraction plus plain arithmetic.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0]  op = i[6:0];
        logic [2:0]  f3 = i[14:12];
        logic [6:0]  f7 = i[31:25];
        logic [31:0] immI = $signed(i) >>> 20;
        logic [31:0] immS = {immI[31:5], i[11:7]};
        logic [31:0] immU = {i[31:12], 12'd0};
        logic [12:0] b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        logic [20:0] j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        logic [31:0] immB = {{19{b13[12]}}, b13};
        logic [31:0] immJ = {{11{j21[20]}}, j21};
        logic [31:0] y, r;
        logic [4:0]  s;
        bit legal = 1, wr = 0, tk = 0;
        e = '{result: 0, store: 0, npc: pc + 4, rd: 0, f3: f3, wen: 0, mren: 0, mwen: 0, ebreak: 0, ill: 0};
        y = (op == 7'h33) ? b : immI;
        s = y[4:0];
        case (f3)
            0: r = (op == 7'h33 && f7 == 7'h20) ? a + (~y + 1) : a + y;
            1: r = a << s;
            2: r = slt_s(a, y);
            3: r = {31'd0, a < y};
            4: r = a ^ y;
            5: r = (a >> s) | ((f7 == 7'h20 && a[31]) ? ~(32'hFFFF_FFFF >> s) : 32'd0);
            6: r = a | y;
            default: r = a & y;
        endcase
        case (op)
            7'h37: begin wr = 1; e.result = immU; end
            7'h17: begin wr = 1; e.result = pc + immU; end
            7'h6f: begin wr = 1; e.result = pc + 4; e.npc = pc + immJ; end
            7'h67: begin legal = (f3 == 0); wr = 1; e.result = pc + 4; e.npc = (a + immI) & 32'hFFFF_FFFE; end
            7'h63: begin
                legal = !(f3 inside {2, 3});
                case (f3)
                    0: tk = (a == b);
                    1: tk = (a != b);
                    4: tk = slt_s(a, b)[0];
                    5: tk = !slt_s(a, b)[0];
                    6: tk = (a < b);
                    default: tk = (a >= b);
                endcase
                if (tk) e.npc = pc + immB;
            end
            7'h03: begin legal = f3 inside {0, 1, 2, 4, 5}; wr = 1; e.mren = 1; e.result = a + immI; end
            7'h23: begin legal = (f3 <= 2); e.mwen = 1; e.store = b; e.result = a + immS; end
            7'h13: begin
                legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1;
                wr = 1; e.result = r;
            end
            7'h33: begin legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); wr = 1; e.result = r; end
            7'h73: begin legal = (i == 32'h0010_0073); e.ebreak = 1; end
            default: legal = 0;
        endcase
        if (!legal) begin
            e = '{result: 0, store: 0, npc: pc + 4, rd: 0, f3: f3, wen: 0, mren: 0, mwen: 0, ebreak: 0, ill: 1};
            wr = 0;
        end
        if (wr) e.rd = i[11:7];
        e.wen = wr && (i[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] rval(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : regs[idx];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, exu_valid}, 0);
        chk("rst_result", exu_result, 0);
        chk("rst_ctrl", {exu_rd_wen, exu_mem_ren, exu_mem_wen, exu_ebreak, exu_illegal}, 0);
        chk("rst_pc", PC, RST_PC);
        chk("rst_imem_addr", imem_addr, RST_PC);
        chk("rst_inst", inst, 0);
        chk("rst_rsaddr", {rs1_addr, rs2_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        mpc = RST_PC;
    endtask

    // One full instruction: launch, wait for valid, compare, optional hold, handshake.
    task automatic run_inst(input logic [31:0] w, input exp_t e, input bit use_start,
                            input int hold, input bit idle_chk);
        int cyc = 0;
        imem_word = w;
        if (use_start) begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc = 1;
        end
        while (!exu_valid && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (idle_chk && cyc == 2) start = 1'b1;
            if (idle_chk && cyc == 3) start = 1'b0;
        end
        start = 1'b0;
        chk("latency", cyc, 3);
        chk("valid", {31'd0, exu_valid}, 1);
        chk("exu_pc", exu_pc, mpc);
        chk("exu_inst", exu_inst, w);
        chk("result", exu_result, e.result);
        chk("store_data", exu_store_data, e.store);
        chk("rd", {27'd0, exu_rd}, {27'd0, e.rd});
        chk("rd_wen", {31'd0, exu_rd_wen}, {31'd0, e.wen});
        chk("mem_ren", {31'd0, exu_mem_ren}, {31'd0, e.mren});
        chk("mem_wen", {31'd0, exu_mem_wen}, {31'd0, e.mwen});
        chk("funct3", {29'd0, exu_funct3}, {29'd0, e.f3});
        chk("ebreak", {31'd0, exu_ebreak}, {31'd0, e.ebreak});
        chk("illegal", {31'd0, exu_illegal}, {31'd0, e.ill});
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, exu_valid}, 1);
            chk("hold_result", exu_result, e.result);
            chk("hold_pc", PC, mpc);
        end
        lsu_ready = 1'b1;
        if (idle_chk) start = 1'b1;
        @(posedge clk);
        #1;
        lsu_ready = 1'b0;
        start = 1'b0;
        chk("valid_drop", {31'd0, exu_valid}, 0);
        chk("next_pc", PC, e.npc);
        mpc = e.npc;
        if (idle_chk) begin
            repeat (3) @(posedge clk);
            #1;
            chk("no_extra_fetch", {31'd0, exu_valid}, 0);
            chk("idle_pc", PC, mpc);
        end
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
        int unsigned k = $urandom_range(0, 10);
        logic [31:0] w = $urandom;
        if (k == 10) return w;
        w[6:0] = ops[k];
        if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
            w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if (k == 9 && $urandom_range(0, 1) == 1) w = 32'h0010_0073;
        return w;
    endfunction

    vec_t vecs [9];

    initial begin
        exp_t e;
        logic [31:0] w;
        vecs[0] = '{1, 32'h0050_0093, 0, 0, 32'd5, 0, 32'h8000_0004, 5'd1, 1, 0, 0, 0};
        vecs[1] = '{0, 32'h0000_0463, 0, 0, 32'd0, 0, 32'h8000_000C, 5'd0, 0, 0, 0, 0};
        vecs[2] = '{1, 32'h0050_0093, 0, 0, 32'd5, 0, 32'h8000_0004, 5'd1, 1, 0, 0, 0};
        vecs[3] = '{0, 32'h0000_1463, 0, 0, 32'd0, 0, 32'h8000_0008, 5'd0, 0, 0, 0, 0};
        vecs[4] = '{1, 32'h0100_00EF, 0, 0, 32'h8000_0004, 0, 32'h8000_0010, 5'd1, 1, 0, 0, 0};
        vecs[5] = '{1, 32'h1234_5137, 32'h100, 32'h1234_5000, 32'h1234_5000, 0, 32'h8000_0004, 5'd2, 1, 0, 0, 0};
        vecs[6] = '{0, 32'h0020_A223, 32'h100, 32'h1234_5000, 32'h104, 32'h1234_5000, 32'h8000_0008, 5'd0, 0, 1, 0, 0};
        vecs[7] = '{0, 32'h0010_0073, 0, 0, 32'd0, 0, 32'h8000_000C, 5'd0, 0, 0, 1, 0};
        vecs[8] = '{0, 32'hFFFF_FFFF, 0, 0, 32'd0, 0, 32'h8000_0010, 5'd0, 0, 0, 0, 1};

        rst = 1'b1; start = 1'b0; lsu_ready = 1'b0; imem_word = '0; mpc = RST_PC;
        for (int i = 0; i < 32; i++) regs[i] = '0;

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].rst_before) do_reset();
            regs[1] = vecs[v].x1;
            regs[2] = vecs[v].x2;
            e = '{result: vecs[v].result, store: vecs[v].store, npc: vecs[v].npc, rd: vecs[v].rd,
                  f3: vecs[v].w[14:12], wen: vecs[v].wen, mren: 1'b0, mwen: vecs[v].mwen,
                  ebreak: vecs[v].ebreak, ill: vecs[v].ill};
            run_inst(vecs[v].w, e, !vecs[v].rst_before, 0, 0);
        end

        // LSU stall for 5 cycles, start during ID and at the handshake edge ignored.
        regs[1] = 32'h0000_0007;
        w = 32'h0030_8113;
        run_inst(w, model(w, mpc, rval(w[19:15]), rval(w[24:20])), 1, 5, 1);

        // Random instructions and register contents against the reference model.
        for (int n = 0; n < 200; n++) begin
            for (int r = 1; r < 32; r++) regs[r] = $urandom;
            w = gen_inst();
            run_inst(w, model(w, mpc, rval(w[19:15]), rval(w[24:20])), 1, $urandom_range(0, 3), 0);
        end

        // Reset while in ID aborts the instruction; refetch from RESET_PC.
        imem_word = 32'h0050_0093;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, exu_valid}, 0);
        chk("abort_result", exu_result, 0);
        chk("abort_pc", PC, RST_PC);
        chk("abort_inst", inst, 0);
        @(negedge clk);
        rst = 1'b0;
        mpc = RST_PC;
        w = 32'h0050_0093;
        run_inst(w, model(w, mpc, 0, 0), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
